radix_test_sequencer: RTL

Self-test controller for the radix-4 multiplier. It seeds the LFSR operand generator, captures each (x, y) pair, and sequences the multiplier through reset, start and wait-for-done. It checks every product against a signed reference, counts failures, and reports a summary after N_VECTORS operations. It sits between the LFSR generator and the radix-4 multiplier core and replaces the generator's fixed start/reset drive.

---
 rtl/radix_pkg.sv | 22 ++
 rtl/radix_ref_check.sv | 22 ++
 rtl/radix_test_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/radix_pkg.sv
// rtl/radix_pkg.sv - shared constants, state encoding and helpers for the radix-4 self-test
package radix_pkg;

    localparam int WIDTH = 8;
    localparam int ERR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        LOAD,
        RST,
        START,
        WAIT,
        CHECK,
        DONE
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/radix_ref_check.sv
// rtl/radix_ref_check.sv - signed WxW reference multiply compared against a 2W-bit product
module radix_ref_check #(
    parameter int W = radix_pkg::WIDTH
) (
    input  logic [W-1:0]   x_i,
    input  logic [W-1:0]   y_i,
    input  logic [2*W-1:0] p_i,
    output logic           mismatch_o
);

    logic signed [2*W-1:0] x_ext;
    logic signed [2*W-1:0] y_ext;
    logic signed [2*W-1:0] expected;

    always_comb begin
        x_ext      = {{W{x_i[W-1]}}, x_i};
        y_ext      = {{W{y_i[W-1]}}, y_i};
        expected   = x_ext * y_ext;
        mismatch_o = (expected != $signed(p_i));
    end

endmodule

// File: rtl/radix_test_sequencer.sv
// rtl/radix_test_sequencer.sv - self-test sequencer driving LFSR operands through the radix-4 multiplier
module radix_test_sequencer #(
    parameter int WIDTH     = radix_pkg::WIDTH,
    parameter int N_VECTORS = 256,
    parameter int TIMEOUT   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       go,
    input  logic [WIDTH-1:0]           gen_x,
    input  logic [WIDTH-1:0]           gen_y,
    output logic                       gen_reset,
    output logic [WIDTH-1:0]           radix_x,
    output logic [WIDTH-1:0]           radix_y,
    output logic                       radix_reset,
    output logic                       radix_start,
    input  logic                       radix_done,
    input  logic [2*WIDTH-1:0]         radix_p,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [radix_pkg::ERR_W-1:0] err_cnt,
    output logic                       timeout_flag,
    output logic [4*WIDTH-1:0]         first_fail
);
    import radix_pkg::*;

    localparam logic [15:0] VEC_LAST  = 16'(N_VECTORS);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t               state_q;
    logic [15:0]          vec_cnt_q;
    logic [15:0]          wait_cnt_q;
    logic [WIDTH-1:0]     x_q;
    logic [WIDTH-1:0]     y_q;
    logic [2*WIDTH-1:0]   p_q;
    logic                 gen_reset_q;
    logic                 radix_reset_q;
    logic                 radix_start_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [ERR_W-1:0]     err_cnt_q;
    logic                 timeout_q;
    logic [4*WIDTH-1:0]   first_fail_q;

    logic                 mismatch;
    logic [ERR_W-1:0]     err_cnt_d;
    logic                 last_vec;
    logic                 first_err;

    radix_ref_check #(.W(WIDTH)) u_ref (
        .x_i        (x_q),
        .y_i        (y_q),
        .p_i        (p_q),
        .mismatch_o (mismatch)
    );

    always_comb begin
        err_cnt_d = sat_inc(err_cnt_q);
        last_vec  = (vec_cnt_q == VEC_LAST);
        first_err = (err_cnt_q == '0);
    end

    // One-cycle strobes default low; each is raised on entry to the state it marks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            vec_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            x_q           <= '0;
            y_q           <= '0;
            p_q           <= '0;
            gen_reset_q   <= 1'b0;
            radix_reset_q <= 1'b0;
            radix_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_cnt_q     <= '0;
            timeout_q     <= 1'b0;
            first_fail_q  <= '0;
        end else begin
            gen_reset_q   <= 1'b0;
            radix_reset_q <= 1'b0;
            radix_start_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        state_q      <= SEED;
                        gen_reset_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        vec_cnt_q    <= '0;
                        err_cnt_q    <= '0;
                        timeout_q    <= 1'b0;
                        first_fail_q <= '0;
                    end
                end
                SEED: state_q <= LOAD;
                LOAD: begin
                    x_q           <= gen_x;
                    y_q           <= gen_y;
                    vec_cnt_q     <= vec_cnt_q + 16'd1;
                    radix_reset_q <= 1'b1;
                    state_q       <= RST;
                end
                RST: begin
                    radix_start_q <= 1'b1;
                    state_q       <= START;
                end
                START: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (radix_done) begin
                        p_q     <= radix_p;
                        state_q <= CHECK;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        timeout_q <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                        if (first_err) first_fail_q <= {x_q, y_q, radix_p};
                        if (last_vec) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b0;
                        end else begin
                            state_q <= LOAD;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_cnt_q <= err_cnt_d;
                        if (first_err) first_fail_q <= {x_q, y_q, p_q};
                    end
                    if (last_vec) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= first_err && !mismatch && !timeout_q;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gen_reset    = gen_reset_q;
    assign radix_x      = x_q;
    assign radix_y      = y_q;
    assign radix_reset  = radix_reset_q;
    assign radix_start  = radix_start_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_cnt      = err_cnt_q;
    assign timeout_flag = timeout_q;
    assign first_fail   = first_fail_q;

endmodule
